r200lsu: RTL
============

Name: r200lsu

Overview:
- Multi-cycle load/store unit for the MEM stage of the r200 5-stage pipeline.
- Consumes EX/MEM outputs (address, store data, access type) and drives a valid/ready data-memory bus.
- Returns sign/zero-extended load data to the MEM/WB register.
- Holds the pipeline via `stall` while a bus transaction is outstanding.
- Replaces the single-cycle combinational data-memory path.

Parameters:
- TIMEOUT, 255: max cycles waiting for `resp_valid` before aborting with error.
- CNT_W, 8: width of timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_res  in  32  effective address from EX/MEM
- rs2o  in  32  store data from EX/MEM
- memrd  in  1  load request
- memwr  in  1  store request
- func3  in  3  access size/sign (RV32I encoding)
- stall  out  1  freeze IF..EX/MEM while high
- dmem_out  out  32  extended load result to MEM/WB
- ld_valid  out  1  one-cycle pulse: `dmem_out` valid
- err  out  1  one-cycle pulse: misaligned/illegal/timeout
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_we  out  1  1 = write
- req_addr  out  32  word-aligned address ({alu_res[31:2],2'b00})
- req_wdata  out  32  lane-positioned store data
- req_wstrb  out  4  byte enables
- resp_valid  in  1  read data / write ack
- resp_rdata  in  32  read word

Behaviour:
- Reset (synchronous): state IDLE, counter 0.
  - `req_valid`=0, `ld_valid`=0, `err`=0, `dmem_out`=0.
  - `stall` = combinational function of state and inputs only.
- Op present = `memrd` | `memwr`.
- Illegal op:
  - `memrd` & `memwr` both high.
  - Load `func3` not in {000,001,010,100,101}.
  - Store `func3` not in {000,001,010}.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - No op: `stall`=0.
  - Illegal op:
    - No bus request; `stall`=0.
    - `err`=1 and `dmem_out`=0 on the next cycle for one cycle; remain IDLE.
  - Legal op:
    - `stall`=1 combinationally in the same cycle.
    - Latch addr/wdata/wstrb/we/func3 into payload registers; go REQ.
- REQ:
  - `req_valid`=1; payload held stable until handshake.
  - On `req_valid` & `req_ready`: `req_valid` drops next cycle, counter cleared, go WAIT.
  - `stall`=1.
- WAIT:
  - `stall`=1; counter increments each cycle.
  - On `resp_valid`:
    - Load: capture extracted data into `dmem_out`.
    - Store: `dmem_out`=0.
    - Go DONE.
  - Counter reaching TIMEOUT without `resp_valid`: `err` pulses in DONE, `dmem_out`=0, go DONE.
  - `resp_valid` and timeout in the same cycle: response wins.
- DONE:
  - `stall`=0; `ld_valid`=1 for loads only (0 for stores/timeout); go IDLE.
  - The pipeline advances at this edge. Next op is sampled in IDLE the following cycle, so minimum occupancy is 3 cycles.
- `resp_valid` outside WAIT: ignored.
- `req_ready` outside REQ: ignored.
- Load extract, with lane = `addr[1:0]` (halfword uses `addr[1]`):
  - LB/LBU: byte[lane], sign-/zero-extended.
  - LH/LHU: half[`addr[1]`], sign-/zero-extended.
  - LW: full word.
- Store:
  - SB: wdata = {4{rs2o[7:0]}}, wstrb = 4'b0001 << lane.
  - SH: wdata = {2{rs2o[15:0]}}, wstrb = 4'b0011 << lane.
  - SW: wdata = rs2o, wstrb = 4'b1111.
  - Loads drive wstrb = 0.
- Reset mid-transaction: next edge forces IDLE with `req_valid`=0. The bus side must tolerate the abandoned request; a late `resp_valid` is ignored.

Decomposition:
- `cpu.vh` gains:
  - LSU state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3).
  - `func3` constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Default TIMEOUT.
- One combinational sub-module `r200lsu_align`:
  - Store direction: `func3`, `addr[1:0]`, `rs2o` → `wdata`, `wstrb`, `illegal`.
  - Load direction: `func3`, `addr[1:0]`, `rdata` → extended load data.
- FSM and timeout counter stay in `r200lsu`.

Test Plan:
- LW addr 0x100, ready same cycle, resp 2 cycles later with 0xDEADBEEF:
  - `req_addr`=0x100, `wstrb`=0.
  - `dmem_out`=0xDEADBEEF, `ld_valid` one pulse, `stall` high exactly from request cycle through WAIT.
- LB addr 0x103, rdata 0x80FF_FF00 → `dmem_out`=0xFFFF_FF80.
- LBU addr 0x103, same rdata → `dmem_out`=0x0000_0080.
- LHU addr 0x102, rdata 0xABCD_1234 → `dmem_out`=0x0000_ABCD.
- SB addr 0x201, rs2o 0x0000_00A5, `req_ready` held low 3 cycles:
  - `req_wdata`=0xA5A5_A5A5, `req_wstrb`=4'b0010, `req_we`=1.
  - Payload stable all 3 cycles, no `ld_valid`.
- LW addr 0x102 → no `req_valid`, `stall`=0, `err` one pulse next cycle.
- LW with no response and TIMEOUT=4:
  - `err` pulse after 4 WAIT cycles, `dmem_out`=0, return to IDLE.
- Reset mid-op: `rst` asserted in WAIT → next cycle IDLE, `req_valid`=0, `stall`=0. A `resp_valid` then is ignored (no `ld_valid`).

Source files
------------

// File: rtl/r200lsu_pkg.sv
// r200lsu_pkg: shared definitions for the r200 MEM-stage load/store unit.
//   - LSU FSM state encodings
//   - RV32I func3 access-size/sign codes used by loads and stores
//   - default response timeout (cycles spent waiting for resp_valid)
package r200lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/r200lsu_align.sv
// r200lsu_align: purely combinational lane logic for the load/store unit.
//   Store side : memrd, memwr, func3, lane, rs2o -> wdata, wstrb, illegal
//   Load side  : ld_func3, ld_lane, rdata        -> ld_data (sign/zero extended)
// The store side looks at the live EX/MEM inputs, while the load side looks
// at the payload latched when the access was accepted.
module r200lsu_align
   import r200lsu_pkg::*;
(
   input  logic        memrd,
   input  logic        memwr,
   input  logic [2:0]  func3,
   input  logic [1:0]  lane,
   input  logic [31:0] rs2o,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        illegal,
   input  logic [2:0]  ld_func3,
   input  logic [1:0]  ld_lane,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Replicate store data across all lanes; byte enables pick the live lane.
   // Loads never write, so their strobes stay zero.
   always_comb begin
      wdata = 32'h0;
      wstrb = 4'b0000;
      case (func3)
         F3_B: begin
            wdata = {4{rs2o[7:0]}};
            wstrb = 4'b0001 << lane;
         end
         F3_H: begin
            wdata = {2{rs2o[15:0]}};
            wstrb = 4'b0011 << lane;
         end
         F3_W: begin
            wdata = rs2o;
            wstrb = 4'b1111;
         end
         default: ;
      endcase
      if (!memwr) begin
         wstrb = 4'b0000;
      end
   end

   // Reject simultaneous read/write, unknown size codes and misalignment.
   always_comb begin
      illegal = 1'b0;
      if (memrd && memwr) begin
         illegal = 1'b1;
      end else if (memrd) begin
         case (func3)
            F3_B, F3_BU: illegal = 1'b0;
            F3_H, F3_HU: illegal = lane[0];
            F3_W:        illegal = (lane != 2'b00);
            default:     illegal = 1'b1;
         endcase
      end else if (memwr) begin
         case (func3)
            F3_B:    illegal = 1'b0;
            F3_H:    illegal = lane[0];
            F3_W:    illegal = (lane != 2'b00);
            default: illegal = 1'b1;
         endcase
      end
   end

   // Pick the addressed byte/half out of the returned word and extend it.
   always_comb begin
      ld_byte = rdata[{ld_lane, 3'b000} +: 8];
      ld_half = ld_lane[1] ? rdata[31:16] : rdata[15:0];
      case (ld_func3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data = {24'h0, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data = {16'h0, ld_half};
         F3_W:    ld_data = rdata;
         default: ld_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/r200lsu.sv
// r200lsu: multi-cycle MEM-stage load/store unit for the r200 pipeline.
//   Pipeline side : alu_res, rs2o, memrd, memwr, func3 in;
//                   stall, dmem_out, ld_valid, err out
//   Bus side      : req_valid/req_ready handshake carrying req_we, req_addr,
//                   req_wdata, req_wstrb; resp_valid/resp_rdata for the reply
// Every legal access walks IDLE -> REQ -> WAIT -> DONE. stall covers the
// accepting IDLE cycle through WAIT; the pipeline moves on at the DONE edge.
module r200lsu
   import r200lsu_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_res,
   input  logic [31:0] rs2o,
   input  logic        memrd,
   input  logic        memwr,
   input  logic [2:0]  func3,
   output logic        stall,
   output logic [31:0] dmem_out,
   output logic        ld_valid,
   output logic        err,
   output logic        req_valid,
   input  logic        req_ready,
   output logic        req_we,
   output logic [31:0] req_addr,
   output logic [31:0] req_wdata,
   output logic [3:0]  req_wstrb,
   input  logic        resp_valid,
   input  logic [31:0] resp_rdata
);

   lsu_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic        we_q;
   logic [2:0]  f3_q;

   logic        op, illegal, legal_op, timeout;
   logic [31:0] st_wdata, ld_data;
   logic [3:0]  st_wstrb;

   assign op       = memrd | memwr;
   assign legal_op = op & ~illegal;
   assign timeout  = (cnt_q == CNT_W'(TIMEOUT - 1));

   r200lsu_align u_align (
      .memrd    (memrd),
      .memwr    (memwr),
      .func3    (func3),
      .lane     (alu_res[1:0]),
      .rs2o     (rs2o),
      .wdata    (st_wdata),
      .wstrb    (st_wstrb),
      .illegal  (illegal),
      .ld_func3 (f3_q),
      .ld_lane  (addr_q[1:0]),
      .rdata    (resp_rdata),
      .ld_data  (ld_data)
   );

   assign req_valid = (state_q == ST_REQ);
   assign req_we    = we_q;
   assign req_addr  = {addr_q[31:2], 2'b00};
   assign req_wdata = wdata_q;
   assign req_wstrb = wstrb_q;

   // Next state and stall. A legal op raises stall in the same IDLE cycle it
   // appears so the pipeline freezes before the payload is even latched.
   // A response arriving on the timeout cycle still counts as a response.
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (legal_op) begin
               stall   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            stall = 1'b1;
            if (req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            stall = 1'b1;
            if (resp_valid || timeout) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, payload, timeout counter and the registered result/pulse outputs.
   // ld_valid and err are set one cycle ahead so they land in DONE (or in the
   // IDLE cycle after an illegal op) and clear themselves the cycle after.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         dmem_out <= 32'h0;
         ld_valid <= 1'b0;
         err      <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         wstrb_q  <= 4'b0000;
         we_q     <= 1'b0;
         f3_q     <= 3'b000;
      end else begin
         state_q  <= state_d;
         ld_valid <= 1'b0;
         err      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (op && illegal) begin
                  err      <= 1'b1;
                  dmem_out <= 32'h0;
               end else if (legal_op) begin
                  addr_q  <= alu_res;
                  wdata_q <= st_wdata;
                  wstrb_q <= st_wstrb;
                  we_q    <= memwr;
                  f3_q    <= func3;
               end
            end
            ST_REQ: begin
               if (req_ready) begin
                  cnt_q <= '0;
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (resp_valid) begin
                  if (we_q) begin
                     dmem_out <= 32'h0;
                  end else begin
                     dmem_out <= ld_data;
                     ld_valid <= 1'b1;
                  end
               end else if (timeout) begin
                  err      <= 1'b1;
                  dmem_out <= 32'h0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
